// File: rtl/monitor_contador.sv
// -----------------------------------------------------------------------------
// monitor_contador
// Watches the output of a 4-bit counter that bounces 0..15..0 and reports
// whether the observed stream follows that bounce sequence.
//
// Ports
//   CLK      in   1  clock, all state changes on rising edge
//   R_N      in   1  synchronous active-low reset (wins over EN)
//   EN       in   1  sample strobe; I is consumed only when EN=1
//   I        in   4  observed counter value
//   DIR      out  1  inferred direction, 0=up 1=down
//   LOCK     out  1  stream currently matches the bounce sequence
//   ERR      out  1  one-cycle pulse on a mismatching sample
//   PEAK     out  1  one-cycle pulse on an in-lock sample of 15
//   VALE     out  1  one-cycle pulse on an in-lock sample of 0
//   ERR_CNT  out  8  saturating mismatch count
//   CYCLES   out  8  completed round trips, wraps at 256
// -----------------------------------------------------------------------------
module monitor_contador (
   input  logic       CLK,
   input  logic       R_N,
   input  logic       EN,
   input  logic [3:0] I,
   output logic       DIR,
   output logic       LOCK,
   output logic       ERR,
   output logic       PEAK,
   output logic       VALE,
   output logic [7:0] ERR_CNT,
   output logic [7:0] CYCLES
);

   typedef enum logic [1:0] {IDLE, PRIMED, LOCKED} state_t;

   state_t     state_q;
   logic [3:0] prev_q;
   logic       dir_q, lock_q, err_q, peak_q, vale_q;
   logic [7:0] err_cnt_q, cycles_q;

   // Next-sample prediction from the last accepted value.
   logic       up_ok, dn_ok;
   logic [3:0] exp_val;
   logic       exp_dir;

   always_comb begin
      // Used while PRIMED: any legal neighbour of PREV locks in a direction.
      up_ok   = (prev_q != 4'd15) && (I == prev_q + 4'd1);
      dn_ok   = (prev_q != 4'd0)  && (I == prev_q - 4'd1);
      exp_val = prev_q + 4'd1;
      exp_dir = dir_q;
      // The end points force a turn-around regardless of current DIR.
      if (prev_q == 4'd15) begin
         exp_val = 4'd14;
         exp_dir = 1'b1;
      end else if (prev_q == 4'd0) begin
         exp_val = 4'd1;
         exp_dir = 1'b0;
      end else if (dir_q) begin
         exp_val = prev_q - 4'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!R_N) begin
         state_q   <= IDLE;
         prev_q    <= 4'd0;
         dir_q     <= 1'b0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         peak_q    <= 1'b0;
         vale_q    <= 1'b0;
         err_cnt_q <= 8'd0;
         cycles_q  <= 8'd0;
      end else begin
         // Pulses default low; they only fire on the edge consuming a sample.
         err_q  <= 1'b0;
         peak_q <= 1'b0;
         vale_q <= 1'b0;
         if (EN) begin
            prev_q <= I;
            case (state_q)
               IDLE: state_q <= PRIMED;
               PRIMED: begin
                  if (up_ok) begin
                     dir_q   <= 1'b0;
                     lock_q  <= 1'b1;
                     state_q <= LOCKED;
                  end else if (dn_ok) begin
                     dir_q   <= 1'b1;
                     lock_q  <= 1'b1;
                     state_q <= LOCKED;
                  end else begin
                     err_q <= 1'b1;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
               LOCKED: begin
                  if (I == exp_val) begin
                     dir_q  <= exp_dir;
                     peak_q <= (I == 4'd15);
                     vale_q <= (I == 4'd0);
                     // A 0 reached on the way down closes one round trip.
                     if (I == 4'd0 && dir_q) cycles_q <= cycles_q + 8'd1;
                  end else begin
                     err_q   <= 1'b1;
                     lock_q  <= 1'b0;
                     state_q <= PRIMED;
                     if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign DIR     = dir_q;
   assign LOCK    = lock_q;
   assign ERR     = err_q;
   assign PEAK    = peak_q;
   assign VALE    = vale_q;
   assign ERR_CNT = err_cnt_q;
   assign CYCLES  = cycles_q;

endmodule

// File: tb/tb_monitor_contador.sv
// -----------------------------------------------------------------------------
// tb_monitor_contador
// Directed vectors for monitor_contador. Each driven cycle pushes the
// hand-derived expected outputs into a queue; an independent monitor pops one
// entry after every rising edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_monitor_contador;

   typedef struct packed {
      logic       dir;
      logic       lock;
      logic       err;
      logic       peak;
      logic       vale;
      logic [7:0] err_cnt;
      logic [7:0] cycles;
   } exp_t;

   logic       CLK = 1'b0;
   logic       R_N = 1'b0;
   logic       EN  = 1'b0;
   logic [3:0] I   = 4'd0;
   logic       DIR, LOCK, ERR, PEAK, VALE;
   logic [7:0] ERR_CNT, CYCLES;

   exp_t sbq[$];
   exp_t last;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   done   = 1'b0;

   monitor_contador dut (
      .CLK(CLK), .R_N(R_N), .EN(EN), .I(I),
      .DIR(DIR), .LOCK(LOCK), .ERR(ERR), .PEAK(PEAK), .VALE(VALE),
      .ERR_CNT(ERR_CNT), .CYCLES(CYCLES)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t mk(input logic d, l, e, p, v,
                               input logic [7:0] ec, cy);
      exp_t r;
      r.dir = d; r.lock = l; r.err = e; r.peak = p; r.vale = v;
      r.err_cnt = ec; r.cycles = cy;
      return r;
   endfunction

   // Monitor: one response per rising edge, sampled 1 time unit after it.
   initial begin : monitor
      exp_t e, got;
      forever begin
         @(posedge CLK);
         #1;
         if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            got = mk(DIR, LOCK, ERR, PEAK, VALE, ERR_CNT, CYCLES);
            n_chk++;
            if (got === e) n_pass++;
            else
               $display("FAIL chk%0d got dir=%b lock=%b err=%b peak=%b vale=%b ec=%0d cy=%0d, need dir=%b lock=%b err=%b peak=%b vale=%b ec=%0d cy=%0d",
                        n_chk, got.dir, got.lock, got.err, got.peak, got.vale,
                        got.err_cnt, got.cycles, e.dir, e.lock, e.err,
                        e.peak, e.vale, e.err_cnt, e.cycles);
         end
      end
   end

   task automatic put(input logic rn, input logic en, input logic [3:0] iv,
                      input exp_t e);
      @(negedge CLK);
      R_N = rn; EN = en; I = iv;
      sbq.push_back(e);
      last = e;
   endtask

   task automatic do_reset();
      put(1'b0, 1'b1, 4'd5, '0);
      put(1'b0, 1'b0, 4'd9, '0);
   endtask

   // Full 0..15..0 trip; with gaps, idle EN=0 cycles hold all levels and
   // keep pulses low.
   task automatic sweep(input bit gaps);
      logic [3:0] v;
      exp_t hold;
      do_reset();
      for (int k = 0; k <= 30; k++) begin
         if (gaps) begin
            int ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) begin
               hold = last;
               hold.err = 1'b0; hold.peak = 1'b0; hold.vale = 1'b0;
               put(1'b1, 1'b0, 4'($urandom_range(0, 15)), hold);
            end
         end
         v = (k <= 15) ? 4'(k) : 4'(30 - k);
         put(1'b1, 1'b1, v,
             mk(k > 15, k >= 1, 1'b0, k == 15, k == 30, 8'd0, (k == 30) ? 8'd1 : 8'd0));
      end
   endtask

   initial begin : stim
      logic [3:0] v;

      // Reset state, sample during reset discarded.
      do_reset();

      // Clean sweep, then the same sweep with random EN gaps.
      sweep(1'b0);
      sweep(1'b1);

      // Locked up at 5, break with 7, relock with 8.
      do_reset();
      for (int k = 0; k <= 5; k++)
         put(1'b1, 1'b1, 4'(k), mk(1'b0, k >= 1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      put(1'b1, 1'b1, 4'd7, mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0));
      put(1'b1, 1'b1, 4'd8, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));
      put(1'b1, 1'b1, 4'd9, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0));

      // Start at 15, 14: locks downward with no PEAK.
      do_reset();
      put(1'b1, 1'b1, 4'd15, '0);
      put(1'b1, 1'b1, 4'd14, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      put(1'b1, 1'b1, 4'd13, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));

      // Reset while locked at 2: clears everything, next sample only primes.
      do_reset();
      put(1'b1, 1'b1, 4'd0, '0);
      put(1'b1, 1'b1, 4'd1, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      put(1'b1, 1'b1, 4'd2, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));
      put(1'b0, 1'b1, 4'd3, '0);
      put(1'b1, 1'b1, 4'd3, '0);
      put(1'b1, 1'b1, 4'd4, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0));

      // 300 mismatches after priming with 8: ERR every sample, count sticks at 255.
      do_reset();
      put(1'b1, 1'b1, 4'd8, '0);
      for (int n = 1; n <= 300; n++) begin
         v = (n % 2 == 1) ? 4'd0 : 4'd8;
         put(1'b1, 1'b1, v,
             mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (n >= 255) ? 8'd255 : 8'(n), 8'd0));
      end

      // Idle and let the monitor drain, bounded.
      @(negedge CLK);
      EN = 1'b0;
      for (int c = 0; c < 10 && sbq.size() > 0; c++) @(posedge CLK);
      #2;
      n_chk++;
      if (sbq.size() == 0) n_pass++;
      else $display("FAIL drain got %0d pending entries, need 0", sbq.size());

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/monitor_contador.md
MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 R_N  input  1  reset, synchronous, active-low; one clock, no other clock domains.
REQ-004 EN  input  1  sample strobe; I is consumed only on edges where EN=1.
REQ-005 I  input  4  observed value from the 0..15..0 up/down bouncing counter.
REQ-006 DIR  output  1  inferred counter direction: 0=up, 1=down.
REQ-007 LOCK  output  1  high while the observed stream matches the bounce sequence.
REQ-008 ERR  output  1  one-cycle pulse on a sequence mismatch.
REQ-009 PEAK  output  1  one-cycle pulse on an accepted in-lock sample of 15.
REQ-010 VALE  output  1  one-cycle pulse on an accepted in-lock sample of 0.
REQ-011 ERR_CNT  output  8  mismatch count, saturating.
REQ-012 CYCLES  output  8  completed round trips, modulo 256.

Function
REQ-013 Legal sequence: 0,1,...,14,15,14,...,1,0,1,...; the stream never wraps 15->0 or 0->15.
REQ-014 Internal state: FSM {IDLE, PRIMED, LOCKED}; 4-bit register PREV holds the last accepted sample.
REQ-015 All outputs SHALL be registered; each response appears on the edge that consumes the sample (visible the cycle after EN=1).
REQ-016 EN=0: state, PREV, DIR, LOCK, ERR_CNT and CYCLES hold; ERR, PEAK and VALE are 0.
REQ-017 IDLE, EN=1: PREV<=I; go to PRIMED; no pulses.
REQ-018 PRIMED, EN=1, I==PREV+1 with PREV<=14, or PREV==0 with I==1: DIR<=0, LOCK<=1, go to LOCKED.
REQ-019 PRIMED, EN=1, I==PREV-1 with PREV>=1, or PREV==15 with I==14: DIR<=1, LOCK<=1, go to LOCKED.
REQ-020 PRIMED, EN=1, any other I: ERR pulse, ERR_CNT increments, PREV<=I, stay in PRIMED.
REQ-021 LOCKED expected value: PREV==15 -> 14 with next DIR=1; PREV==0 -> 1 with next DIR=0; otherwise PREV+1 if DIR=0, PREV-1 if DIR=1.
REQ-022 LOCKED, EN=1, I==expected: PREV<=I; DIR updates per REQ-021; PEAK=1 if I==15; VALE=1 if I==0.
REQ-023 CYCLES increments by 1 (wrapping 255->0) on every accepted in-lock sample I==0 arriving with DIR=1.
REQ-024 LOCKED, EN=1, I!=expected: ERR pulse, ERR_CNT increments, LOCK<=0, PREV<=I, go to PRIMED; DIR holds.
REQ-025 ERR_CNT saturates at 255; further mismatches still pulse ERR.
REQ-026 PEAK and VALE are never asserted outside LOCKED acceptance; ERR never coincides with PEAK or VALE.

Reset
REQ-027 When R_N=0 at a rising CLK: state<=IDLE, PREV=0, DIR=0, LOCK=0, ERR=0, PEAK=0, VALE=0, ERR_CNT=0, CYCLES=0.
REQ-028 Reset SHALL take priority over EN; a sample presented during reset is discarded.
REQ-029 Reset mid-lock SHALL fully resynchronise; the first sample after reset only primes the block.

Verification
REQ-030 Reset, then EN=1 with I=0,1,...,15,14,...,0 -> LOCK=1 after sample 1; PEAK once after 15; DIR=1 after 14; VALE after final 0; CYCLES=1; ERR_CNT=0.
REQ-031 Locked up at 5, then I=7 -> ERR pulse, ERR_CNT=1, LOCK=0; then I=8 -> LOCK=1, DIR=0, no ERR.
REQ-032 First samples 15, 14 after reset -> LOCK=1, DIR=1, no PEAK, no ERR.
REQ-033 Legal sequence with random EN=0 gaps -> identical responses to the gap-free run; no pulses during gaps.
REQ-034 300 consecutive mismatching samples (alternating I=0 and I=8) -> ERR pulses on every sample; ERR_CNT stops at 255.
REQ-035 R_N=0 with EN=1, I=3 while LOCKED at 2 -> all outputs 0 next cycle; next sample primes only (LOCK stays 0).
